// File: rtl/scan_sequencer.sv
// Channel sweep sequencer driving a 4-to-16 decoder: each channel is held for
// dwell+1 cycles, followed by a one-cycle blank so adjacent channels never overlap.
module scan_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [3:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  output logic               E,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               D,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

  state_t             r_state;
  logic               r_mode;
  logic [3:0]         r_last;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;
  logic [3:0]         r_code;
  logic               r_e;
  logic               r_busy;
  logic               r_done;
  logic               r_wrap;

  assign E          = r_e;
  assign {A,B,C,D}  = r_code;
  assign busy       = r_busy;
  assign done       = r_done;
  assign wrap       = r_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_last  <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_code  <= '0;
      r_e     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_mode  <= mode;
            r_last  <= last;
            r_dwell <= dwell;
            r_cnt   <= '0;
            r_code  <= '0;
            r_e     <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_e     <= 1'b0;
            r_code  <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == r_dwell) begin
            r_state <= S_BLANK;
            r_e     <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BLANK: begin
          // stop outranks the terminal-channel decision, so an abort never yields done/wrap
          if (stop) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_busy  <= 1'b0;
          end else if (r_code != r_last) begin
            r_code  <= r_code + 4'd1;
            r_e     <= 1'b1;
            r_state <= S_ACTIVE;
          end else if (!r_mode) begin
            r_code  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_code  <= '0;
            r_e     <= 1'b1;
            r_wrap  <= 1'b1;
            r_state <= S_ACTIVE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_e     <= 1'b0;
          r_code  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed vector table plus hand sequences for the multi-cycle corners of scan_sequencer.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [3:0] last = '0;
  logic [7:0] dwell = '0;
  logic       E, A, B, C, D, busy, done, wrap;

  int total = 0;
  int bad   = 0;

  // vector: inputs applied before a rising edge, outputs expected just after it
  typedef struct {
    logic       start, stop, mode;
    logic [3:0] last;
    logic [7:0] dwell;
    logic [7:0] exp;   // {E, code[3:0], busy, done, wrap}
  } vec_t;

  vec_t vecs[$];

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .last(last), .dwell(dwell), .E(E), .A(A), .B(B), .C(C), .D(D),
    .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic e, input logic [3:0] code,
                                    input logic bz, input logic dn, input logic wr);
    return {e, code, bz, dn, wr};
  endfunction

  task automatic add(input logic st, input logic sp, input logic md,
                     input logic [3:0] ls, input logic [7:0] dw, input logic [7:0] ex);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.last = ls; v.dwell = dw; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] exp);
    logic [7:0] got;
    got = {E, A, B, C, D, busy, done, wrap};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {E,code,busy,done,wrap}=%b required %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("reset_state", pk(0, 4'd0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    add(0, 0, 0, 4'd0, 8'd0, pk(0, 4'd0, 0, 0, 0));
    add(1, 1, 0, 4'd3, 8'd2, pk(0, 4'd0, 0, 0, 0));   // start+stop in idle
    // single sweep last=3 dwell=2; start held and last/dwell altered mid-sweep
    add(1, 0, 0, 4'd3, 8'd2, pk(1, 4'd0, 1, 0, 0));
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 3; k++)
        if (!(ch == 0 && k == 0)) add(1, 0, 0, 4'd0, 8'd0, pk(1, 4'(ch), 1, 0, 0));
      add(1, 0, 0, 4'd0, 8'd0, pk(0, 4'(ch), 1, 0, 0));
    end
    add(1, 0, 0, 4'd0, 8'd0, pk(0, 4'd0, 0, 1, 0));   // done, 16 cycles after first E
    add(0, 0, 0, 4'd0, 8'd0, pk(0, 4'd0, 0, 0, 0));
    // continuous sweep last=1 dwell=0; mode/last/dwell changed mid-sweep
    add(1, 0, 1, 4'd1, 8'd0, pk(1, 4'd0, 1, 0, 0));
    add(0, 0, 0, 4'd0, 8'd5, pk(0, 4'd0, 1, 0, 0));
    add(0, 0, 0, 4'd0, 8'd5, pk(1, 4'd1, 1, 0, 0));
    add(0, 0, 0, 4'd0, 8'd5, pk(0, 4'd1, 1, 0, 0));
    add(0, 0, 0, 4'd0, 8'd5, pk(1, 4'd0, 1, 0, 1));
    add(0, 0, 0, 4'd0, 8'd5, pk(0, 4'd0, 1, 0, 0));
    add(0, 0, 0, 4'd0, 8'd5, pk(1, 4'd1, 1, 0, 0));
    add(0, 0, 0, 4'd0, 8'd5, pk(0, 4'd1, 1, 0, 0));
    add(0, 0, 0, 4'd0, 8'd5, pk(1, 4'd0, 1, 0, 1));
    add(0, 1, 0, 4'd0, 8'd5, pk(0, 4'd0, 0, 0, 0));   // stop from ACTIVE
    add(0, 0, 0, 4'd0, 8'd0, pk(0, 4'd0, 0, 0, 0));
    // stop in terminal BLANK of single sweep: no done
    add(1, 0, 0, 4'd0, 8'd0, pk(1, 4'd0, 1, 0, 0));
    add(0, 0, 0, 4'd0, 8'd0, pk(0, 4'd0, 1, 0, 0));
    add(0, 1, 0, 4'd0, 8'd0, pk(0, 4'd0, 0, 0, 0));
    add(0, 0, 0, 4'd0, 8'd0, pk(0, 4'd0, 0, 0, 0));

    foreach (vecs[i]) begin
      start = vecs[i].start; stop = vecs[i].stop; mode = vecs[i].mode;
      last = vecs[i].last;   dwell = vecs[i].dwell;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // last=15, dwell=0: every code visited, done 32 cycles after first E
    start = 1; stop = 0; mode = 0; last = 4'd15; dwell = 8'd0;
    tick();
    start = 0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("l15_c%0d", i), pk((i % 2) == 0, 4'(i / 2), 1, 0, 0));
      tick();
    end
    chk("l15_done", pk(0, 4'd0, 0, 1, 0));
    tick();
    chk("l15_idle", pk(0, 4'd0, 0, 0, 0));

    // dwell=255: 256-cycle hold
    start = 1; last = 4'd0; dwell = 8'd255;
    tick();
    start = 0;
    begin
      int n;
      n = 0;
      while (E && n < 300) begin
        n++;
        tick();
      end
      total++;
      if (n != 256) begin
        bad++;
        $display("FAIL dwell255_hold: got %0d cycles required 256", n);
      end
    end
    chk("dwell255_blank", pk(0, 4'd0, 1, 0, 0));
    tick();
    chk("dwell255_done", pk(0, 4'd0, 0, 1, 0));

    // asynchronous reset mid-ACTIVE at code 5
    start = 1; last = 4'd7; dwell = 8'd3;
    tick();
    start = 0;
    begin
      int n;
      n = 0;
      while (!({A, B, C, D} == 4'd5 && E) && n < 100) begin
        n++;
        tick();
      end
      total++;
      if (n >= 100) begin
        bad++;
        $display("FAIL reach_code5: timed out after %0d cycles", n);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", pk(0, 4'd0, 0, 0, 0));
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_reset_idle%0d", i), pk(0, 4'd0, 0, 0, 0));
    end
    start = 1; last = 4'd2; dwell = 8'd1;
    tick();
    chk("restart", pk(1, 4'd0, 1, 0, 0));
    start = 0; stop = 1;
    tick();
    chk("restart_stop", pk(0, 4'd0, 0, 0, 0));
    stop = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-count input and internal dwell counter.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin a sweep; sampled only in IDLE.
REQ-005 stop  input  1  abort request; sampled in ACTIVE and BLANK.
REQ-006 mode  input  1  0 = single sweep, 1 = continuous sweep; captured at start.
REQ-007 last  input  4  highest channel code in the sweep (0..15); captured at start.
REQ-008 dwell  input  DWELL_W  channel hold length minus one; captured at start.
REQ-009 E  output  1  registered enable to the downstream 4-to-16 decoder.
REQ-010 A, B, C, D  output  1 each  registered channel code, A = MSB, D = LSB.
REQ-011 busy  output  1  high in ACTIVE and BLANK.
REQ-012 done  output  1  one-cycle pulse on normal completion of a single sweep.
REQ-013 wrap  output  1  one-cycle pulse each time a continuous sweep restarts at code 0.

Function
REQ-014 States SHALL be IDLE, ACTIVE, BLANK. All outputs SHALL be registered.
REQ-015 IDLE: E=0, code {A,B,C,D}=0, busy=0. start=1 with stop=0 SHALL capture mode, last, dwell into internal registers; next cycle is ACTIVE with E=1, code=0.
REQ-016 ACTIVE: E=1 for exactly dwell_q+1 consecutive cycles per channel. dwell_q=0 gives 1 cycle. Max 2^DWELL_W cycles. The counter SHALL clear on every ACTIVE entry.
REQ-017 After the final ACTIVE cycle the block SHALL enter BLANK for exactly one cycle with E=0 and code unchanged. This guarantees no decoder output overlap between channels.
REQ-018 BLANK with code != last_q: next cycle ACTIVE with code+1.
REQ-019 BLANK with code == last_q and mode_q=0: next cycle IDLE, code=0, done=1 for that one cycle.
REQ-020 BLANK with code == last_q and mode_q=1: next cycle ACTIVE with code=0, wrap=1 for that one cycle.
REQ-021 Code increment SHALL be 4-bit. last=15 reaches code 15 and then follows REQ-019 or REQ-020. The code SHALL never pass last_q.
REQ-022 stop=1 in ACTIVE or BLANK: next cycle IDLE, E=0, code=0, done=0, wrap=0. stop SHALL take priority over every other transition, including a simultaneous terminal BLANK.
REQ-023 start while busy SHALL be ignored. start and stop both high in IDLE: remain IDLE.
REQ-024 Changes to mode, last, or dwell during a sweep SHALL have no effect until the next start.
REQ-025 Single-sweep length from first E=1 to the done cycle SHALL be (last_q+1)*(dwell_q+2) cycles.
REQ-026 At most one of E and done SHALL be high in any cycle. done and wrap SHALL never be high together.

Reset
REQ-027 rst_n=0 SHALL immediately, without clk, force IDLE, E=0, code=0, busy=0, done=0, wrap=0, and clear the captured registers and dwell counter.
REQ-028 Reset mid-sweep SHALL abort with no done pulse. After rst_n deassertion the block SHALL wait in IDLE for a new start.

Verification
REQ-029 Single sweep, last=3, dwell=2, mode=0 -> codes 0,1,2,3 each with E=1 for 3 cycles, separated by 1-cycle E=0 gaps; done pulses once, 16 cycles after the first E=1; busy falls with done.
REQ-030 Continuous sweep, last=1, dwell=0, mode=1 -> E pattern 1,0,1,0,... with codes 0,0,1,1,0,0,...; wrap pulses every 4 cycles; done stays 0; stop -> E=0, code=0 next cycle.
REQ-031 Boundaries: last=15, dwell=0 -> all 16 codes visited, code 15 never increments to 0 within the sweep, done after 32 cycles. dwell=255 -> 256-cycle hold per channel.
REQ-032 stop asserted in the terminal BLANK of a single sweep -> IDLE next cycle with done=0. start held high during busy -> no restart, no change in sequence.
REQ-033 rst_n pulled low asynchronously mid-ACTIVE (code=5) -> outputs zero before the next clk edge. After release, no activity until start; change last/dwell mid-sweep -> the sequence is unaffected.
